// File: rtl/text_string_builder.sv
// text_string_builder
// Builds the packed ASCII string shown by the text-overlay pixel generator:
// a caller-supplied prefix followed by the decimal rendering of a binary
// value. The binary-to-decimal conversion runs sequentially (double-dabble),
// and the visible outputs change only on the single edge that raises done.
module text_string_builder #(
    parameter int MAX_TEXT_WIDTH = 20,
    parameter int PREFIX_CHARS   = 12,
    parameter int VALUE_BITS     = 8,
    parameter int DIGITS         = 3
) (
    input  logic                        clock,
    input  logic                        resetn,
    input  logic                        start,
    input  logic [PREFIX_CHARS*8-1:0]   prefix,
    input  logic [5:0]                  prefixLength,
    input  logic [VALUE_BITS-1:0]       value,
    input  logic                        suppressZeros,
    output logic [MAX_TEXT_WIDTH*8-1:0] textString,
    output logic [5:0]                  stringLength,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    localparam int TEXT_BITS = MAX_TEXT_WIDTH * 8;
    localparam int BCD_BITS  = DIGITS * 4;
    // One counter serves both the conversion and the emit phase.
    localparam int CNT_W     = (VALUE_BITS > DIGITS) ? $clog2(VALUE_BITS + 1)
                                                     : $clog2(DIGITS + 1);

    localparam logic [5:0]       PREFIX_CAP   = 6'(PREFIX_CHARS);
    localparam logic [5:0]       TEXT_CAP     = 6'(MAX_TEXT_WIDTH);
    localparam logic [CNT_W-1:0] CONVERT_LAST = CNT_W'(VALUE_BITS - 1);
    localparam logic [CNT_W-1:0] EMIT_LAST    = CNT_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_EMIT    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                 state_reg;
    logic [TEXT_BITS-1:0]   text_reg;      // working string, newest char in [7:0]
    logic [5:0]             len_reg;       // working string length
    logic [VALUE_BITS-1:0]  shift_reg;     // binary bits still to be shifted in
    logic [BCD_BITS-1:0]    bcd_reg;       // BCD accumulator, MS digit on top
    logic [CNT_W-1:0]       cnt_reg;       // step counter within a phase
    logic                   ovf_reg;       // truncation seen during this build
    logic                   seen_reg;      // a nonzero digit has been emitted
    logic                   suppress_reg;  // latched suppressZeros

    // Prefix length handling: clamp to the prefix capacity, then to the output.
    logic [5:0]             prefix_len_clamp;
    logic                   prefix_clipped;
    logic [5:0]             start_len;
    logic [TEXT_BITS-1:0]   prefix_fit;

    assign prefix_len_clamp = (prefixLength > PREFIX_CAP) ? PREFIX_CAP : prefixLength;
    assign prefix_clipped   = (prefix_len_clamp > TEXT_CAP);
    assign start_len        = prefix_clipped ? TEXT_CAP : prefix_len_clamp;

    // Mask the prefix to its valid bytes. Bytes above the output capacity are
    // simply not carried, which discards the oldest characters when clipping.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_TEXT_WIDTH; gi++) begin : gen_prefix_fit
            if (gi < PREFIX_CHARS) begin : gen_byte
                assign prefix_fit[gi*8 +: 8] =
                    (6'(gi) < prefix_len_clamp) ? prefix[gi*8 +: 8] : 8'h00;
            end else begin : gen_pad
                assign prefix_fit[gi*8 +: 8] = 8'h00;
            end
        end
    endgenerate

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    logic [BCD_BITS-1:0] bcd_adj;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : gen_bcd_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Emit-phase helpers: digits leave the top of the BCD register MS first.
    logic [3:0] digit;
    logic [7:0] digit_char;
    logic       last_digit;
    logic       skip_digit;
    logic       text_full;

    assign digit      = bcd_reg[BCD_BITS-1 -: 4];
    assign digit_char = {4'h3, digit};
    assign last_digit = (cnt_reg == EMIT_LAST);
    // Leading zeros are dropped on request, but the final digit always stays.
    assign skip_digit = suppress_reg && (digit == 4'd0) && !seen_reg && !last_digit;
    assign text_full  = (len_reg >= TEXT_CAP);

    // Build sequencer with registered status and result outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg    <= S_IDLE;
            text_reg     <= '0;
            len_reg      <= '0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            seen_reg     <= 1'b0;
            suppress_reg <= 1'b0;
            textString   <= '0;
            stringLength <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            // busy trails the state by one edge, so it stays high through the
            // done cycle; the idle gate below uses it to refuse a start there.
            busy <= (state_reg != S_IDLE);
            done <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (start && !busy) begin
                        text_reg     <= prefix_fit;
                        len_reg      <= start_len;
                        ovf_reg      <= prefix_clipped;
                        shift_reg    <= value;
                        bcd_reg      <= '0;
                        cnt_reg      <= '0;
                        seen_reg     <= 1'b0;
                        suppress_reg <= suppressZeros;
                        state_reg    <= S_CONVERT;
                    end
                end

                S_CONVERT: begin
                    {bcd_reg, shift_reg} <= {bcd_adj[BCD_BITS-2:0], shift_reg, 1'b0};
                    if (cnt_reg == CONVERT_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= S_EMIT;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_EMIT: begin
                    bcd_reg  <= bcd_reg << 4;
                    seen_reg <= seen_reg | (digit != 4'd0);
                    if (!skip_digit) begin
                        if (!text_full) begin
                            text_reg <= (text_reg << 8) | TEXT_BITS'(digit_char);
                            len_reg  <= len_reg + 6'd1;
                        end else begin
                            ovf_reg <= 1'b1;
                        end
                    end
                    if (last_digit) begin
                        cnt_reg   <= '0;
                        state_reg <= S_DONE;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    done         <= 1'b1;
                    textString   <= text_reg;
                    stringLength <= len_reg;
                    overflow     <= ovf_reg;
                    state_reg    <= S_IDLE;
                end

                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_string_builder.sv
// Bench for text_string_builder: a default-size instance and an 8-character
// instance share the same stimulus; table vectors, hand-written timing/abort
// sequences and randomized builds are checked against a queue-based model.
module tb_text_string_builder;

    localparam int PC = 12;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [95:0]  prefix = '0;
    logic [5:0]   prefixLength = '0;
    logic [7:0]   value = '0;
    logic         suppressZeros = 1'b0;

    logic [159:0] textString;
    logic [5:0]   stringLength;
    logic         busy, done, overflow;

    logic [63:0]  text8;
    logic [5:0]   len8;
    logic         busy8, done8, ovf8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    text_string_builder dut (
        .clock(clock), .resetn(resetn), .start(start),
        .prefix(prefix), .prefixLength(prefixLength), .value(value),
        .suppressZeros(suppressZeros),
        .textString(textString), .stringLength(stringLength),
        .busy(busy), .done(done), .overflow(overflow)
    );

    text_string_builder #(.MAX_TEXT_WIDTH(8)) dut8 (
        .clock(clock), .resetn(resetn), .start(start),
        .prefix(prefix), .prefixLength(prefixLength), .value(value),
        .suppressZeros(suppressZeros),
        .textString(text8), .stringLength(len8),
        .busy(busy8), .done(done8), .overflow(ovf8)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [159:0] str2vec(input string s);
        logic [159:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) v[(s.len()-1-i)*8 +: 8] = s[i];
        return v;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the string is the clamped prefix followed by the decimal
    // text of the value, cut to the capacity (oldest prefix chars go first,
    // then trailing digits are dropped).
    task automatic model(input logic [95:0] pre, input logic [5:0] plen,
                         input logic [7:0] val, input logic sup, input int cap,
                         output logic [159:0] text, output logic [5:0] len,
                         output logic ovf);
        byte unsigned q[$];
        string ds;
        int n;
        n = (int'(plen) > PC) ? PC : int'(plen);
        ovf = 1'b0;
        for (int i = n - 1; i >= 0; i--) q.push_back(pre[i*8 +: 8]);
        while (q.size() > cap) begin
            void'(q.pop_front());
            ovf = 1'b1;
        end
        ds = $sformatf("%0d", val);
        if (!sup) while (ds.len() < 3) ds = {"0", ds};
        for (int i = 0; i < ds.len(); i++) begin
            if (q.size() < cap) q.push_back(ds[i]);
            else ovf = 1'b1;
        end
        text = '0;
        for (int j = 0; j < q.size(); j++) text[(q.size()-1-j)*8 +: 8] = q[j];
        len = 6'(q.size());
    endtask

    // Runs one build starting #1 after an edge with busy low; returns #1
    // after the edge on which busy falls.
    task automatic do_build(input logic [95:0] pre, input logic [5:0] plen,
                            input logic [7:0] val, input logic sup);
        int lat, busy_cnt;
        logic stable;
        logic [159:0] hold_t;
        logic [5:0] hold_l;
        prefix = pre; prefixLength = plen; value = val; suppressZeros = sup;
        start = 1'b1;
        hold_t = textString;
        hold_l = stringLength;
        @(posedge clock); #1;
        start = 1'b0;
        prefix = {$urandom(), $urandom(), $urandom()};
        prefixLength = 6'($urandom());
        value = 8'($urandom());
        suppressZeros = ~sup;
        lat = 0; busy_cnt = 0; stable = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (textString !== hold_t || stringLength !== hold_l) stable = 1'b0;
            @(posedge clock); #1;
            lat++;
            if (busy === 1'b1) busy_cnt++;
        end
        check_int("done_latency", lat, 12);
        check_int("busy_cycles", busy_cnt, 12);
        check_int("hold_stable", int'(stable), 1);
        check_int("done8_aligned", int'(done8), 1);
        @(posedge clock); #1;
        check_int("done_one_cycle", int'(done), 0);
        check_int("busy_fall", int'(busy), 0);
    endtask

    task automatic cmp_result(input string tag,
                              input logic [159:0] t20, input logic [5:0] l20, input logic o20,
                              input logic [159:0] t8, input logic [5:0] l8, input logic o8);
        $display("%s: len=%0d ovf=%0d len8=%0d ovf8=%0d", tag, stringLength, overflow, len8, ovf8);
        check_vec({tag, ".text"}, textString, t20);
        check_int({tag, ".len"}, int'(stringLength), int'(l20));
        check_int({tag, ".ovf"}, int'(overflow), int'(o20));
        check_vec({tag, ".text8"}, 160'(text8), t8);
        check_int({tag, ".len8"}, int'(len8), int'(l8));
        check_int({tag, ".ovf8"}, int'(ovf8), int'(o8));
    endtask

    typedef struct {
        string      pre;
        logic [5:0] plen;
        logic [7:0] val;
        logic       sup;
        string      t20;
        logic [5:0] l20;
        logic       o20;
        string      t8;
        logic [5:0] l8;
        logic       o8;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input string p, input logic [5:0] pl, input logic [7:0] v, input logic s,
                           input string a, input logic [5:0] al, input logic ao,
                           input string b, input logic [5:0] bl, input logic bo);
        vec_t e;
        e.pre = p; e.plen = pl; e.val = v; e.sup = s;
        e.t20 = a; e.l20 = al; e.o20 = ao;
        e.t8 = b;  e.l8 = bl;  e.o8 = bo;
        vq.push_back(e);
    endtask

    initial begin
        logic [159:0] e20, e8;
        logic [5:0]   el20, el8;
        logic         eo20, eo8;
        logic [95:0]  rp;
        logic [5:0]   rl;
        logic [7:0]   rv;
        logic         rs;
        int           n_done, done_at;

        add_vec("SCORE:", 6'd6, 8'd7,   1'b1, "SCORE:7",   6'd7, 1'b0, "SCORE:7",  6'd7, 1'b0);
        add_vec("SCORE:", 6'd6, 8'd255, 1'b1, "SCORE:255", 6'd9, 1'b0, "SCORE:25", 6'd8, 1'b1);
        add_vec("SCORE:", 6'd6, 8'd0,   1'b1, "SCORE:0",   6'd7, 1'b0, "SCORE:0",  6'd7, 1'b0);
        add_vec("SCORE:", 6'd6, 8'd7,   1'b0, "SCORE:007", 6'd9, 1'b0, "SCORE:00", 6'd8, 1'b1);
        add_vec("",       6'd0, 8'd42,  1'b1, "42",        6'd2, 1'b0, "42",       6'd2, 1'b0);
        add_vec("SCORE:", 6'd6, 8'd123, 1'b1, "SCORE:123", 6'd9, 1'b0, "SCORE:12", 6'd8, 1'b1);
        add_vec("SCORE:", 6'd6, 8'd5,   1'b1, "SCORE:5",   6'd7, 1'b0, "SCORE:5",  6'd7, 1'b0);
        add_vec("MOVES_PLAYED", 6'd12, 8'd200, 1'b1, "MOVES_PLAYED200", 6'd15, 1'b0, "S_PLAYED", 6'd8, 1'b1);
        add_vec("XYZ",    6'd2, 8'd9,   1'b0, "YZ009",     6'd5, 1'b0, "YZ009",    6'd5, 1'b0);
        add_vec("SCORE:", 6'd6, 8'd100, 1'b1, "SCORE:100", 6'd9, 1'b0, "SCORE:10", 6'd8, 1'b1);
        add_vec("ABCDEFGHIJKL", 6'd12, 8'd0, 1'b0, "ABCDEFGHIJKL000", 6'd15, 1'b0, "EFGHIJKL", 6'd8, 1'b1);
        add_vec("HI",     6'd2, 8'd99,  1'b1, "HI99",      6'd4, 1'b0, "HI99",     6'd4, 1'b0);
        add_vec("",       6'd0, 8'd0,   1'b0, "000",       6'd3, 1'b0, "000",      6'd3, 1'b0);

        // Reset state
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_vec("reset.text", textString, '0);
        check_int("reset.len", int'(stringLength), 0);
        check_int("reset.busy", int'(busy), 0);
        check_int("reset.done", int'(done), 0);
        check_int("reset.ovf", int'(overflow), 0);
        check_vec("reset.text8", 160'(text8), '0);
        resetn = 1'b1;
        @(posedge clock); #1;

        // Table vectors
        for (int i = 0; i < vq.size(); i++) begin
            do_build(96'(str2vec(vq[i].pre)), vq[i].plen, vq[i].val, vq[i].sup);
            cmp_result($sformatf("vec%0d", i), str2vec(vq[i].t20), vq[i].l20, vq[i].o20,
                       str2vec(vq[i].t8), vq[i].l8, vq[i].o8);
        end

        // Start pulses during a build (edge k+4) and on the done-cycle edge
        // (k+13, busy still high) are both ignored.
        prefix = 96'(str2vec("P=")); prefixLength = 6'd2; value = 8'd33; suppressZeros = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        value = 8'd77;
        n_done = 0; done_at = -1;
        for (int n = 1; n <= 30; n++) begin
            start = (n == 4 || n == 13);
            @(posedge clock); #1;
            if (done === 1'b1) begin
                n_done++;
                done_at = n;
            end
            if (n == 14) check_int("late_start_busy", int'(busy), 0);
        end
        start = 1'b0;
        check_int("ignored.done_count", n_done, 1);
        check_int("ignored.done_edge", done_at, 12);
        cmp_result("ignored", str2vec("P=33"), 6'd4, 1'b0, str2vec("P=33"), 6'd4, 1'b0);

        // Reset at edge k+6 aborts the build
        prefix = 96'(str2vec("SCORE:")); prefixLength = 6'd6; value = 8'd88; suppressZeros = 1'b1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        check_vec("abort.text", textString, '0);
        check_int("abort.len", int'(stringLength), 0);
        check_int("abort.busy", int'(busy), 0);
        check_int("abort.ovf", int'(overflow), 0);
        check_vec("abort.text8", 160'(text8), '0);
        resetn = 1'b1;
        n_done = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clock); #1;
            if (done === 1'b1 || done8 === 1'b1) n_done++;
        end
        check_int("abort.no_done", n_done, 0);
        do_build(96'(str2vec("SCORE:")), 6'd6, 8'd88, 1'b1);
        cmp_result("after_abort", str2vec("SCORE:88"), 6'd8, 1'b0, str2vec("SCORE:88"), 6'd8, 1'b0);

        // Randomized builds against the model
        for (int i = 0; i < 150; i++) begin
            for (int b = 0; b < PC; b++) rp[b*8 +: 8] = 8'($urandom_range(33, 126));
            rl = 6'($urandom_range(0, 15));
            rv = (i % 5 == 0) ? 8'($urandom_range(0, 9)) : 8'($urandom());
            rs = 1'($urandom());
            model(rp, rl, rv, rs, 20, e20, el20, eo20);
            model(rp, rl, rv, rs, 8, e8, el8, eo8);
            do_build(rp, rl, rv, rs);
            cmp_result($sformatf("rand%0d", i), e20, el20, eo20, e8, el8, eo8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_string_builder.md
Name: text_string_builder

Overview:
- Producer side of the text-overlay string interface: composes the packed ASCII `textString`/`stringLength` pair that the text pixel generator consumes.
- Concatenates a caller-supplied ASCII prefix with the unsigned decimal rendering of a binary value, for example a "SCORE:" prefix followed by a score or move counter.
- Binary-to-decimal conversion is sequential (double-dabble). Outputs update atomically on completion so the LCD scan never sees a half-built string.

Parameters:
- MAX_TEXT_WIDTH, 20, capacity of the output string in characters.
- PREFIX_CHARS, 12, capacity of the prefix input in characters.
- VALUE_BITS, 8, width of the binary value.
- DIGITS, 3, number of BCD digits. Integrator guarantees 10^DIGITS > 2^VALUE_BITS - 1.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  request a build; sampled only in IDLE.
- prefix  input  PREFIX_CHARS*8  ASCII prefix, right-aligned: last character in bits [7:0].
- prefixLength  input  6  number of valid prefix characters.
- value  input  VALUE_BITS  unsigned number to append.
- suppressZeros  input  1  1 = drop leading zeros (at least one digit always kept).
- textString  output  MAX_TEXT_WIDTH*8  packed result. Last character in bits [7:0]; first character in byte stringLength-1; unused upper bytes are 0.
- stringLength  output  6  number of valid characters.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when textString/stringLength update.
- overflow  output  1  result was truncated; valid with done, held until the next done.

Behaviour:
- Reset (resetn=0 at a rising edge): state=IDLE; textString=0, stringLength=0, busy=0, done=0, overflow=0. Reset mid-operation aborts the build; no done is produced.
- States: IDLE -> CONVERT -> EMIT -> DONE -> IDLE.
- IDLE: on start=1, latch inputs.
  - Working string W = prefix masked to its low min(prefixLength, PREFIX_CHARS) bytes.
  - Working length L = min(prefixLength, PREFIX_CHARS).
  - Shift register = value; BCD register = 0; internal overflow flag = 0.
  - Go to CONVERT.
- CONVERT, exactly VALUE_BITS cycles. Each cycle: add 3 to every BCD nibble >= 5, then shift {BCD, shift register} left by 1.
- EMIT, exactly DIGITS cycles, most-significant digit first. Each cycle:
  - The digit is skipped if suppressZeros=1, the digit is 0, no nonzero digit has been emitted yet, and it is not the final digit.
  - Otherwise, if L < MAX_TEXT_WIDTH: W = (W << 8) | (0x30 + digit), L = L + 1.
  - Otherwise the digit is dropped and the internal overflow flag is set.
  - Prefix clipping also sets overflow: if the clamped prefix length exceeds MAX_TEXT_WIDTH, L clamps to MAX_TEXT_WIDTH, the oldest prefix characters are discarded, and overflow is set.
- DONE, one cycle: done=1; textString<=W, stringLength<=L, overflow<=internal flag, all on the same edge; next state IDLE.
- Latency: start sampled at edge k; busy=1 from edge k+1; done=1 for the cycle following edge k+1+VALUE_BITS+DIGITS, which is edge k+12 at defaults. busy falls at edge k+13.
- start while busy=1 is ignored; it is not queued.
- A new start may be accepted in the cycle busy=0 immediately after DONE.
- textString and stringLength are stable except on the done edge.
- Inputs may change after the start edge without affecting the build in progress.

Test Plan:
- Reset, then prefix="SCORE:", prefixLength=6, value=7, suppressZeros=1, start at edge k -> done at edge k+12; textString low 7 bytes = "SCORE:7"; stringLength=7; overflow=0; busy high for edges k+1..k+12.
- value=255, same prefix, suppressZeros=1 -> "SCORE:255", stringLength=9. value=0 -> "SCORE:0", stringLength=7.
- value=7, suppressZeros=0 -> "SCORE:007", stringLength=9. prefixLength=0 with value=42 and suppressZeros=1 -> "42", stringLength=2, upper bytes 0.
- MAX_TEXT_WIDTH=8, prefix "SCORE:", value=123 -> "SCORE:12", stringLength=8, overflow=1. A following build with value=5 -> "SCORE:5", overflow=0.
- Second start pulsed at edge k+4 during a build -> ignored; exactly one done, with the first build's result.
- resetn=0 at edge k+6 mid-CONVERT -> outputs return to reset values at that edge; no done. A new start after reset completes normally.
